// File: rtl/except_ctrl.sv
// -----------------------------------------------------------------------------
// except_ctrl
//
// Exception / ERET sequencer. It accepts one classified event per pass and
// walks IDLE -> FLUSH -> BLANK -> IDLE. In FLUSH it emits a one-cycle pipeline
// flush with a redirect target. For ordinary exceptions it also emits a
// one-cycle CP0 commit strobe carrying EPC, Cause.BD and ExcCode. For ERET it
// emits an EXL clear instead. New events are ignored for BLANK_CYC cycles
// after the flush.
//
// Optional feature macro: EXCEPT_CTRL_BADVADDR_EN
//   defined   : address errors (0x04/0x05) latch bad_addr_i and commit BadVAddr
//   undefined : BadVAddr outputs are tied to 0 and no latch is built
//
// Parameters
//   HANDLER_ADDR  exception entry vector (all non-ERET events)
//   BLANK_CYC     post-flush blanking length in cycles (1..15)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   excepttype_i        encoded event (0 = none)
//   pc_i                PC of the faulting instruction
//   in_delayslot_i      faulting instruction sits in a branch delay slot
//   bad_addr_i          faulting data/fetch address
//   cp0_epc_i           current CP0 EPC (ERET target)
//   stall_i             pipeline stall, blocks acceptance in IDLE
//   flush_o, newpc_o    flush pulse and redirect target
//   cp0_we_o            commit strobe for cp0_epc_o / cp0_bd_o / cp0_exccode_o
//   cp0_exl_clr_o       EXL clear strobe (ERET)
//   cp0_badvaddr_we_o   BadVAddr commit strobe, cp0_badvaddr_o value
//   busy_o              sequencer is not in IDLE
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for an acceptable event
//   S_FLUSH | single cycle: flush + redirect + CP0 strobes
//   S_BLANK | counting down the blanking window, events ignored
// -----------------------------------------------------------------------------
module except_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'hBFC00380,
  parameter int unsigned BLANK_CYC    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        stall_i,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        cp0_we_o,
  output logic [31:0] cp0_epc_o,
  output logic        cp0_bd_o,
  output logic [4:0]  cp0_exccode_o,
  output logic        cp0_exl_clr_o,
  output logic        cp0_badvaddr_we_o,
  output logic [31:0] cp0_badvaddr_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  localparam logic [3:0]  BLANK_LOAD = 4'(BLANK_CYC - 1);
  localparam logic [31:0] ET_INT     = 32'h0000_0001;
  localparam logic [31:0] ET_ERET    = 32'h0000_000e;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        code_ok;
  logic        accept;

  logic        eret_q;
  logic [31:0] newpc_q;
  logic [31:0] epc_q;
  logic        bd_q;
  logic [4:0]  exccode_q;

  // Only the codes the classifier can legitimately produce are accepted;
  // anything else is treated as "no event".
  always_comb begin
    code_ok = 1'b0;
    case (excepttype_i)
      32'h01, 32'h04, 32'h05, 32'h08,
      32'h09, 32'h0a, 32'h0c, 32'h0e: code_ok = 1'b1;
      default:                         code_ok = 1'b0;
    endcase
  end

  assign accept = (state == S_IDLE) && !stall_i && code_ok;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_BLANK;
      S_BLANK: if (cnt == 4'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Blanking down-counter: loaded on the FLUSH->BLANK transition, the BLANK
  // cycle that sees zero is the last one, so BLANK lasts BLANK_CYC cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (state == S_FLUSH) begin
      cnt <= BLANK_LOAD;
    end else if (state == S_BLANK && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Event capture. Everything the FLUSH cycle needs is taken at acceptance so
  // later changes on the inputs cannot disturb the commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eret_q    <= 1'b0;
      newpc_q   <= 32'h0;
      epc_q     <= 32'h0;
      bd_q      <= 1'b0;
      exccode_q <= 5'd0;
    end else if (accept) begin
      eret_q    <= (excepttype_i == ET_ERET);
      newpc_q   <= (excepttype_i == ET_ERET) ? cp0_epc_i : HANDLER_ADDR;
      // Delay-slot faults restart at the branch; subtraction wraps at 0.
      epc_q     <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
      bd_q      <= in_delayslot_i;
      // Interrupts are encoded as 0x01 by the classifier but use ExcCode 0.
      exccode_q <= (excepttype_i == ET_INT) ? 5'd0 : excepttype_i[4:0];
    end
  end

`ifdef EXCEPT_CTRL_BADVADDR_EN
  logic        badv_q;
  logic [31:0] badvaddr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badv_q     <= 1'b0;
      badvaddr_q <= 32'h0;
    end else if (accept) begin
      badv_q <= (excepttype_i == 32'h04) || (excepttype_i == 32'h05);
      if ((excepttype_i == 32'h04) || (excepttype_i == 32'h05))
        badvaddr_q <= bad_addr_i;
    end
  end
`else
  logic unused_bad_addr;
  assign unused_bad_addr = ^bad_addr_i;
`endif

  // Output logic: strobes only ever come from the FLUSH state, data outputs
  // simply expose the captured values.
  always_comb begin
    flush_o           = (state == S_FLUSH);
    cp0_we_o          = (state == S_FLUSH) && !eret_q;
    cp0_exl_clr_o     = (state == S_FLUSH) &&  eret_q;
    busy_o            = (state != S_IDLE);
    newpc_o           = newpc_q;
    cp0_epc_o         = epc_q;
    cp0_bd_o          = bd_q;
    cp0_exccode_o     = exccode_q;
`ifdef EXCEPT_CTRL_BADVADDR_EN
    cp0_badvaddr_we_o = (state == S_FLUSH) && badv_q;
    cp0_badvaddr_o    = badvaddr_q;
`else
    cp0_badvaddr_we_o = 1'b0;
    cp0_badvaddr_o    = 32'h0;
`endif
  end

endmodule

// File: tb/tb_except_ctrl.sv
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] excepttype;
  logic [31:0] pc;
  logic        in_ds;
  logic [31:0] bad_addr;
  logic [31:0] epc_in;
  logic        stall;
  logic        flush;
  logic [31:0] newpc;
  logic        cp0_we;
  logic [31:0] cp0_epc;
  logic        cp0_bd;
  logic [4:0]  cp0_exccode;
  logic        exl_clr;
  logic        badv_we;
  logic [31:0] badvaddr;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  except_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .excepttype_i      (excepttype),
    .pc_i              (pc),
    .in_delayslot_i    (in_ds),
    .bad_addr_i        (bad_addr),
    .cp0_epc_i         (epc_in),
    .stall_i           (stall),
    .flush_o           (flush),
    .newpc_o           (newpc),
    .cp0_we_o          (cp0_we),
    .cp0_epc_o         (cp0_epc),
    .cp0_bd_o          (cp0_bd),
    .cp0_exccode_o     (cp0_exccode),
    .cp0_exl_clr_o     (exl_clr),
    .cp0_badvaddr_we_o (badv_we),
    .cp0_badvaddr_o    (badvaddr),
    .busy_o            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    excepttype = 32'h0;
    pc         = 32'h0;
    in_ds      = 1'b0;
    bad_addr   = 32'h0;
    epc_in     = 32'h0;
    stall      = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) step();
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] bad_codes [2];
    bad_codes[0] = 32'h02;
    bad_codes[1] = 32'h0b;

    clr_in();
    rst = 1'b1;
    #12;
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_newpc", newpc,          32'h0);
    chk("rst_epc",   cp0_epc,        32'h0);
    chk("rst_badv",  badvaddr,       32'h0);
    rst = 1'b0;
    step();

    // Syscall
    excepttype = 32'h08; pc = 32'h80001000; in_ds = 1'b0;
    step();
    excepttype = 32'h0;
    chk("sys_flush",   {31'd0, flush},   32'd1);
    chk("sys_newpc",   newpc,            32'hBFC00380);
    chk("sys_we",      {31'd0, cp0_we},  32'd1);
    chk("sys_exl",     {31'd0, exl_clr}, 32'd0);
    chk("sys_exccode", {27'd0, cp0_exccode}, 32'd8);
    chk("sys_epc",     cp0_epc,          32'h80001000);
    chk("sys_bd",      {31'd0, cp0_bd},  32'd0);
    chk("sys_busy1",   {31'd0, busy},    32'd1);
    step();
    chk("sys_flush_blank", {31'd0, flush},  32'd0);
    chk("sys_we_blank",    {31'd0, cp0_we}, 32'd0);
    chk("sys_busy2",       {31'd0, busy},   32'd1);
    chk("sys_hold_epc",    cp0_epc,         32'h80001000);
    step();
    chk("sys_busy3", {31'd0, busy}, 32'd1);
    step();
    chk("sys_busy4", {31'd0, busy}, 32'd0);

    // Delay-slot overflow
    excepttype = 32'h0c; pc = 32'h80002004; in_ds = 1'b1;
    step();
    clr_in();
    chk("ov_flush",   {31'd0, flush},  32'd1);
    chk("ov_epc",     cp0_epc,         32'h80002000);
    chk("ov_bd",      {31'd0, cp0_bd}, 32'd1);
    chk("ov_exccode", {27'd0, cp0_exccode}, 32'd12);
    wait_idle();

    // ERET: target sampled at acceptance, input changed afterwards
    excepttype = 32'h0e; epc_in = 32'h80003008;
    step();
    clr_in();
    epc_in = 32'h12345678;
    chk("eret_flush", {31'd0, flush},   32'd1);
    chk("eret_newpc", newpc,            32'h80003008);
    chk("eret_exl",   {31'd0, exl_clr}, 32'd1);
    chk("eret_we",    {31'd0, cp0_we},  32'd0);
    chk("eret_bvwe",  {31'd0, badv_we}, 32'd0);
    wait_idle();

    // AdEL
    excepttype = 32'h04; pc = 32'h80005000; bad_addr = 32'h00000003;
    step();
    clr_in();
    chk("adel_flush",   {31'd0, flush},  32'd1);
    chk("adel_we",      {31'd0, cp0_we}, 32'd1);
    chk("adel_newpc",   newpc,           32'hBFC00380);
    chk("adel_exccode", {27'd0, cp0_exccode}, 32'd4);
`ifdef EXCEPT_CTRL_BADVADDR_EN
    chk("adel_bvwe", {31'd0, badv_we}, 32'd1);
    chk("adel_bv",   badvaddr,         32'h00000003);
`else
    chk("adel_bvwe", {31'd0, badv_we}, 32'd0);
    chk("adel_bv",   badvaddr,         32'h0);
`endif
    wait_idle();

    // EPC wrap at address 0 in a delay slot
    excepttype = 32'h0a; pc = 32'h0; in_ds = 1'b1;
    step();
    clr_in();
    chk("wrap_epc",     cp0_epc,         32'hFFFFFFFC);
    chk("wrap_bd",      {31'd0, cp0_bd}, 32'd1);
    chk("wrap_exccode", {27'd0, cp0_exccode}, 32'd10);
    wait_idle();

    // Unsupported codes are ignored
    for (int i = 0; i < 2; i++) begin
      excepttype = bad_codes[i];
      step();
      chk("badcode_flush", {31'd0, flush}, 32'd0);
      chk("badcode_busy",  {31'd0, busy},  32'd0);
    end
    clr_in();

    // Stall holds off acceptance, blanking ignores a new event
    excepttype = 32'h09; pc = 32'h80006000; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_flush", {31'd0, flush}, 32'd0);
      chk("stall_busy",  {31'd0, busy},  32'd0);
    end
    stall = 1'b0;
    step();
    chk("unstall_flush",   {31'd0, flush}, 32'd1);
    chk("unstall_exccode", {27'd0, cp0_exccode}, 32'd9);
    excepttype = 32'h01; pc = 32'h80007000;
    step();
    chk("blank1_flush", {31'd0, flush}, 32'd0);
    chk("blank1_exc",   {27'd0, cp0_exccode}, 32'd9);
    step();
    chk("blank2_flush", {31'd0, flush}, 32'd0);
    chk("blank2_busy",  {31'd0, busy},  32'd1);
    step();
    chk("exit_flush", {31'd0, flush}, 32'd0);
    chk("exit_busy",  {31'd0, busy},  32'd0);
    step();
    clr_in();
    chk("int_flush",   {31'd0, flush}, 32'd1);
    chk("int_exccode", {27'd0, cp0_exccode}, 32'd0);
    chk("int_epc",     cp0_epc,        32'h80007000);
    wait_idle();

    // Asynchronous reset in the middle of FLUSH
    excepttype = 32'h08; pc = 32'h80004000;
    step();
    chk("rstf_flush_pre", {31'd0, flush}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstf_flush", {31'd0, flush},  32'd0);
    chk("rstf_we",    {31'd0, cp0_we}, 32'd0);
    chk("rstf_busy",  {31'd0, busy},   32'd0);
    chk("rstf_epc",   cp0_epc,         32'h0);
    clr_in();
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_flush", {31'd0, flush},  32'd0);
      chk("post_rst_we",    {31'd0, cp0_we}, 32'd0);
      chk("post_rst_busy",  {31'd0, busy},   32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
